// File: rtl/serv_wfi_ctrl.sv
// WFI sequencer: drains the core, requests clock halt, wakes on a locally enabled irq, then retires the WFI.
// Runs on the free-running clock; records the wake cause and a saturating count of sleep cycles.
module serv_wfi_ctrl #(
    parameter     RESET_STRATEGY = "MINI",
    parameter int WAKE_DELAY     = 2,
    parameter int CNT_W          = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wfi,
    input  logic             i_core_idle,
    input  logic             i_timer_irq,
    input  logic             i_external_irq,
    input  logic             i_mtie,
    input  logic             i_meie,
    output logic             o_sleep_req,
    output logic             o_wfi_done,
    output logic [1:0]       o_wake_cause,
    output logic [CNT_W-1:0] o_sleep_cycles,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } state_t;

    localparam logic [3:0] WAKE_LAST = 4'(WAKE_DELAY);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wake_cnt;
    logic       timer_pend;
    logic       ext_pend;
    logic       pend;
    logic       wake_last;
    logic       enter_wake;

    // mstatus.MIE is not consulted: WFI wakes on any locally enabled interrupt.
    assign timer_pend = i_timer_irq & i_mtie;
    assign ext_pend   = i_external_irq & i_meie;
    assign pend       = timer_pend | ext_pend;

    assign wake_last  = (state == WAKE) && (wake_cnt == WAKE_LAST);
    assign enter_wake = (state != WAKE) && (state_nxt == WAKE);
    assign o_wfi_done = wake_last;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (i_wfi) begin
                    state_nxt = pend ? WAKE : DRAIN;
                end
            end
            DRAIN: begin
                if (pend) begin
                    state_nxt = WAKE;
                end else if (i_core_idle) begin
                    state_nxt = SLEEP;
                end
            end
            SLEEP: begin
                if (pend) begin
                    state_nxt = WAKE;
                end
            end
            WAKE: begin
                if (wake_last) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= RUN;
            o_sleep_req <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_sleep_req <= (state_nxt == SLEEP);
            o_busy      <= (state_nxt != RUN);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wake_cnt <= 4'd0;
        end else if (enter_wake) begin
            wake_cnt <= 4'd0;
        end else if (state == WAKE) begin
            wake_cnt <= wake_cnt + 4'd1;
        end
    end

    // Statistics registers; left unreset when the datapath reset is stripped.
    always_ff @(posedge i_clk) begin
        if (i_rst && (RESET_STRATEGY != "NONE")) begin
            o_wake_cause   <= 2'b00;
            o_sleep_cycles <= '0;
        end else begin
            if (enter_wake) begin
                o_wake_cause <= {ext_pend, timer_pend};
            end
            if ((state == SLEEP) && !(&o_sleep_cycles)) begin
                o_sleep_cycles <= o_sleep_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serv_wfi_ctrl.sv
// Bench for serv_wfi_ctrl: directed scenarios plus random traffic against a behavioural model.
// A second instance with a 4-bit counter shares all inputs to observe saturation.
module tb_serv_wfi_ctrl;
    localparam int WD = 2;

    logic clk = 1'b0;
    logic rst, wfi, idle, tirq, eirq, mtie, meie;
    logic sleep_req, done, busy;
    logic [1:0] cause;
    logic [15:0] scyc;
    logic s_sleep_req, s_done, s_busy;
    logic [1:0] s_cause;
    logic [3:0] s_scyc;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serv_wfi_ctrl #(.RESET_STRATEGY("MINI"), .WAKE_DELAY(WD), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_wfi(wfi), .i_core_idle(idle),
        .i_timer_irq(tirq), .i_external_irq(eirq), .i_mtie(mtie), .i_meie(meie),
        .o_sleep_req(sleep_req), .o_wfi_done(done), .o_wake_cause(cause),
        .o_sleep_cycles(scyc), .o_busy(busy)
    );

    serv_wfi_ctrl #(.RESET_STRATEGY("MINI"), .WAKE_DELAY(WD), .CNT_W(4)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_wfi(wfi), .i_core_idle(idle),
        .i_timer_irq(tirq), .i_external_irq(eirq), .i_mtie(mtie), .i_meie(meie),
        .o_sleep_req(s_sleep_req), .o_wfi_done(s_done), .o_wake_cause(s_cause),
        .o_sleep_cycles(s_scyc), .o_busy(s_busy)
    );

    // Reference: a WFI is in flight from acceptance until retirement; while asleep each cycle counts;
    // a wake countdown of WD cycles ends in the retirement pulse.
    bit       m_in_wfi = 1'b0;
    bit       m_asleep = 1'b0;
    int       m_wake_left = -1;
    logic [1:0] m_cause = 2'b00;
    int       m_cnt = 0;
    wire      m_pend = (tirq & mtie) | (eirq & meie);
    wire      m_done = (m_wake_left == 0);

    always @(posedge clk) begin
        if (rst) begin
            m_in_wfi <= 1'b0; m_asleep <= 1'b0; m_wake_left <= -1; m_cause <= 2'b00; m_cnt <= 0;
        end else if (m_wake_left >= 0) begin
            if (m_wake_left == 0) begin
                m_in_wfi <= 1'b0; m_wake_left <= -1;
            end else begin
                m_wake_left <= m_wake_left - 1;
            end
        end else if (!m_in_wfi) begin
            if (wfi) begin
                m_in_wfi <= 1'b1;
                if (m_pend) begin
                    m_wake_left <= WD; m_cause <= {eirq & meie, tirq & mtie};
                end
            end
        end else begin
            if (m_asleep) m_cnt <= m_cnt + 1;
            if (m_pend) begin
                m_asleep <= 1'b0; m_wake_left <= WD; m_cause <= {eirq & meie, tirq & mtie};
            end else if (idle) begin
                m_asleep <= 1'b1;
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1; wfi = 0; idle = 0; tirq = 0; eirq = 0; mtie = 0; meie = 0;
        cyc(2);
        checks++; if ({sleep_req, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {sleep_req, busy, done}); end
        checks++; if (cause !== 2'b00) begin errors++; $display("FAIL reset_cause: got %b expected 00", cause); end
        checks++; if (scyc !== 16'd0) begin errors++; $display("FAIL reset_cycles: got %0d expected 0", scyc); end
        checks++; if (s_scyc !== 4'd0) begin errors++; $display("FAIL reset_cycles4: got %0d expected 0", s_scyc); end
        rst = 0;
        cyc(1);
    endtask

    task automatic test_basic_sleep;
        idle = 1; mtie = 1; meie = 0; tirq = 0; eirq = 0;
        wfi = 1; cyc(1); wfi = 0;
        checks++; if ({busy, sleep_req} !== 2'b10) begin errors++; $display("FAIL basic_drain: got %b expected 10", {busy, sleep_req}); end
        cyc(1);
        for (int i = 2; i <= 10; i++) begin
            checks++; if (sleep_req !== 1'b1) begin errors++; $display("FAIL basic_sleep_req: cycle T+%0d got %b expected 1", i, sleep_req); end
            if (i == 10) tirq = 1;
            cyc(1);
        end
        checks++; if ({sleep_req, busy, done} !== 3'b010) begin errors++; $display("FAIL basic_wake: got %b expected 010", {sleep_req, busy, done}); end
        cyc(2);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done); end
        checks++; if (cause !== 2'b01) begin errors++; $display("FAIL basic_cause: got %b expected 01", cause); end
        checks++; if (scyc !== 16'd9) begin errors++; $display("FAIL basic_cycles: got %0d expected 9", scyc); end
        cyc(1);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL basic_run: got %b expected 00", {done, busy}); end
        tirq = 0; mtie = 0;
        cyc(1);
    endtask

    task automatic test_drain_hold;
        bit seen;
        idle = 0; mtie = 1;
        wfi = 1; cyc(1); wfi = 0;
        for (int i = 1; i <= 5; i++) begin
            checks++; if ({busy, sleep_req} !== 2'b10) begin errors++; $display("FAIL drain_hold: T+%0d got %b expected 10", i, {busy, sleep_req}); end
            if (i == 5) idle = 1;
            cyc(1);
        end
        checks++; if (sleep_req !== 1'b1) begin errors++; $display("FAIL drain_to_sleep: got %b expected 1", sleep_req); end
        tirq = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin cyc(1); seen = done; end
        checks++; if (!seen) begin errors++; $display("FAIL drain_exit_done: got 0 expected 1 within 10 cycles"); end
        tirq = 0; mtie = 0;
        cyc(1);
        // interrupt arriving during drain: wake without ever requesting sleep
        idle = 0; meie = 1; eirq = 0;
        wfi = 1; cyc(1); wfi = 0;
        cyc(2);
        eirq = 1;
        checks++; if ({busy, sleep_req} !== 2'b10) begin errors++; $display("FAIL drain_irq_pre: got %b expected 10", {busy, sleep_req}); end
        cyc(1);
        checks++; if ({busy, sleep_req} !== 2'b10) begin errors++; $display("FAIL drain_irq_wake: got %b expected 10", {busy, sleep_req}); end
        checks++; if (cause !== 2'b10) begin errors++; $display("FAIL drain_irq_cause: got %b expected 10", cause); end
        cyc(WD);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL drain_irq_done: got %b expected 1", done); end
        eirq = 0; meie = 0; idle = 1;
        cyc(1);
    endtask

    task automatic test_masking;
        bit seen;
        idle = 1; mtie = 0; meie = 0;
        wfi = 1; cyc(1); wfi = 0;
        cyc(1);
        tirq = 1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            checks++; if (sleep_req !== 1'b1) begin errors++; $display("FAIL mask_stay: got %b expected 1", sleep_req); end
        end
        mtie = 1;
        cyc(1);
        checks++; if ({busy, sleep_req} !== 2'b10) begin errors++; $display("FAIL mask_wake: got %b expected 10", {busy, sleep_req}); end
        seen = done;
        for (int i = 0; i < 10 && !seen; i++) begin cyc(1); seen = done; end
        checks++; if (!seen) begin errors++; $display("FAIL mask_done: got 0 expected 1 within 10 cycles"); end
        checks++; if (cause !== 2'b01) begin errors++; $display("FAIL mask_cause: got %b expected 01", cause); end
        tirq = 0; mtie = 0;
        cyc(1);
    endtask

    task automatic test_pending_at_wfi;
        tirq = 1; eirq = 1; mtie = 1; meie = 1;
        wfi = 1; cyc(1); wfi = 0;
        for (int i = 1; i <= 3; i++) begin
            checks++; if (sleep_req !== 1'b0) begin errors++; $display("FAIL pend_sleep_req: T+%0d got %b expected 0", i, sleep_req); end
            checks++; if (done !== (i == 3)) begin errors++; $display("FAIL pend_done: T+%0d got %b expected %b", i, done, i == 3); end
            if (i < 3) cyc(1);
        end
        checks++; if (cause !== 2'b11) begin errors++; $display("FAIL pend_cause: got %b expected 11", cause); end
        tirq = 0; eirq = 0; mtie = 0; meie = 0;
        cyc(1);
    endtask

    task automatic test_saturation;
        int ndone;
        idle = 1;
        wfi = 1; cyc(1); wfi = 0;
        for (int i = 0; i < 22; i++) begin
            wfi = (i % 5 == 0);
            cyc(1);
        end
        wfi = 0; mtie = 1; tirq = 1;
        cyc(1);
        ndone = 0;
        for (int i = 1; i <= 10; i++) begin
            wfi = (i <= 2);
            ndone += int'(done);
            cyc(1);
        end
        wfi = 0;
        checks++; if (ndone != 1) begin errors++; $display("FAIL sat_done_count: got %0d expected 1", ndone); end
        checks++; if (s_scyc !== 4'hF) begin errors++; $display("FAIL sat_cycles4: got %0d expected 15", s_scyc); end
        checks++; if (scyc !== 16'(m_cnt)) begin errors++; $display("FAIL sat_cycles16: got %0d expected %0d", scyc, m_cnt); end
        tirq = 0; mtie = 0;
        cyc(1);
    endtask

    task automatic test_reset_in_sleep;
        int ndone;
        idle = 1;
        wfi = 1; cyc(1); wfi = 0;
        cyc(2);
        checks++; if (sleep_req !== 1'b1) begin errors++; $display("FAIL rst_pre_sleep: got %b expected 1", sleep_req); end
        rst = 1;
        cyc(1);
        rst = 0;
        checks++; if ({sleep_req, busy, done} !== 3'b000) begin errors++; $display("FAIL rst_sleep_ctrl: got %b expected 000", {sleep_req, busy, done}); end
        checks++; if ({scyc, cause} !== 18'd0) begin errors++; $display("FAIL rst_sleep_stats: got %0d/%b expected 0/00", scyc, cause); end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin cyc(1); ndone += int'(done) + int'(busy); end
        checks++; if (ndone != 0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", ndone); end
    endtask

    task automatic test_random;
        int sat16, sat4;
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 499) == 0);
            wfi  = ($urandom_range(0, 7) == 0);
            idle = ($urandom_range(0, 3) != 0);
            tirq = ($urandom_range(0, 11) == 0);
            eirq = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 15) == 0) mtie = 1'($urandom);
            if ($urandom_range(0, 15) == 0) meie = 1'($urandom);
            cyc(1);
            sat16 = (m_cnt > 65535) ? 65535 : m_cnt;
            sat4  = (m_cnt > 15) ? 15 : m_cnt;
            checks++;
            if ({sleep_req, busy, done, cause} !== {m_asleep, m_in_wfi, m_done, m_cause}) begin
                errors++;
                if (errors < 20) $display("FAIL rand_ctrl: n=%0d got %b expected %b", n, {sleep_req, busy, done, cause}, {m_asleep, m_in_wfi, m_done, m_cause});
            end
            checks++;
            if ({scyc, s_scyc} !== {16'(sat16), 4'(sat4)}) begin
                errors++;
                if (errors < 20) $display("FAIL rand_cycles: n=%0d got %0d/%0d expected %0d/%0d", n, scyc, s_scyc, sat16, sat4);
            end
            checks++;
            if ({s_sleep_req, s_busy, s_done, s_cause} !== {sleep_req, busy, done, cause}) begin
                errors++;
                if (errors < 20) $display("FAIL rand_sat_ctrl: n=%0d got %b expected %b", n, {s_sleep_req, s_busy, s_done, s_cause}, {sleep_req, busy, done, cause});
            end
        end
        rst = 0; wfi = 0;
    endtask

    initial begin
        test_reset();
        test_basic_sleep();
        test_drain_hold();
        test_masking();
        test_pending_at_wfi();
        test_saturation();
        test_reset_in_sleep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
